// File: rtl/tron_frame_sequencer.sv
// Pixel-stream sequencer for the Tron VGA path: round-robin player heads plus timer bar,
// then a full-screen clear, then per-player rank glyphs. One registered pixel per clock.
module tron_frame_sequencer #(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int TIMER_Y     = 119,
  parameter int GLYPH_W     = 5,
  parameter int GLYPH_H     = 7,
  parameter int GLYPH_X0    = 33,
  parameter int GLYPH_PITCH = 30,
  parameter int GLYPH_Y0    = 42
) (
  input  logic                                   CLOCK_50,
  input  logic                                   resetn,
  input  logic                                   start,
  input  logic                                   tick,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]       player_pos,
  input  logic [NUM_PLAYERS*3-1:0]               player_colour,
  input  logic [NUM_PLAYERS*3-1:0]               rank_colour,
  input  logic [NUM_PLAYERS*GLYPH_W*GLYPH_H-1:0] glyph_bits,
  output logic [X_W-1:0]                         x,
  output logic [Y_W-1:0]                         y,
  output logic [2:0]                             colour,
  output logic                                   plot,
  output logic                                   running,
  output logic                                   done
);

  localparam int PW     = X_W + Y_W;
  localparam int GN     = GLYPH_W * GLYPH_H;
  localparam int SLOT_W = $clog2(NUM_PLAYERS + 1);
  localparam int K_W    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CX_W   = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int CY_W   = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam int GP_W   = (GN > 1) ? $clog2(GN) : 1;
  localparam int GC_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int GR_W   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

  typedef enum logic [2:0] {IDLE, PLAY, CLEAR, GLYPH, DONE} state_t;

  state_t              state, state_next;
  logic [SLOT_W-1:0]   slot, slot_next;
  logic [CX_W-1:0]     timer_x, timer_x_next;
  logic                expired, expired_next;
  logic [CX_W-1:0]     cx, cx_next;
  logic [CY_W-1:0]     cy, cy_next;
  logic [GP_W-1:0]     gp, gp_next;
  logic [GC_W-1:0]     gcol, gcol_next;
  logic [GR_W-1:0]     grow, grow_next;
  logic [K_W-1:0]      gk, gk_next;
  logic [X_W-1:0]      x_next;
  logic [Y_W-1:0]      y_next;
  logic [2:0]          colour_next;
  logic                plot_next, running_next, done_next;

  logic [PW-1:0] pos_arr [NUM_PLAYERS];
  logic [2:0]    pcol_arr[NUM_PLAYERS];
  logic [2:0]    rcol_arr[NUM_PLAYERS];
  logic [GN-1:0] glyph_arr[NUM_PLAYERS];
  logic [PW-1:0] cur_pos;
  logic [GP_W-1:0] bit_idx;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_unpack
    assign pos_arr[gi]   = player_pos[gi*PW +: PW];
    assign pcol_arr[gi]  = player_colour[gi*3 +: 3];
    assign rcol_arr[gi]  = rank_colour[gi*3 +: 3];
    assign glyph_arr[gi] = glyph_bits[gi*GN +: GN];
  end

  assign cur_pos = pos_arr[slot[K_W-1:0]];
  // Bitmaps are row-major with pixel 0 at the MSB.
  assign bit_idx = GP_W'(GN - 1) - gp;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      slot    <= '0;
      timer_x <= '0;
      expired <= 1'b0;
      cx      <= '0;
      cy      <= '0;
      gp      <= '0;
      gcol    <= '0;
      grow    <= '0;
      gk      <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      slot    <= slot_next;
      timer_x <= timer_x_next;
      expired <= expired_next;
      cx      <= cx_next;
      cy      <= cy_next;
      gp      <= gp_next;
      gcol    <= gcol_next;
      grow    <= grow_next;
      gk      <= gk_next;
      x       <= x_next;
      y       <= y_next;
      colour  <= colour_next;
      plot    <= plot_next;
      running <= running_next;
      done    <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    slot_next    = slot;
    timer_x_next = timer_x;
    expired_next = expired;
    cx_next      = cx;
    cy_next      = cy;
    gp_next      = gp;
    gcol_next    = gcol;
    grow_next    = grow;
    gk_next      = gk;
    x_next       = '0;
    y_next       = '0;
    colour_next  = '0;
    plot_next    = 1'b0;
    running_next = 1'b0;
    done_next    = 1'b0;

    case (state)
      IDLE, DONE: begin
        done_next = (state == DONE);
        if (start) begin
          state_next   = PLAY;
          timer_x_next = '0;
          expired_next = 1'b0;
          slot_next    = '0;
        end
      end

      PLAY: begin
        running_next = 1'b1;
        plot_next    = 1'b1;
        if (tick) begin
          if (timer_x == CX_W'(SCREEN_W - 1)) expired_next = 1'b1;
          else                                timer_x_next = timer_x + 1'b1;
        end
        if (slot == SLOT_W'(NUM_PLAYERS)) begin
          // Timer slot draws the pre-tick position; expiry only acts at the sweep boundary.
          x_next      = X_W'(timer_x);
          y_next      = Y_W'(TIMER_Y);
          colour_next = 3'b111;
          slot_next   = '0;
          if (expired_next) begin
            state_next = CLEAR;
            cx_next    = '0;
            cy_next    = '0;
          end
        end else begin
          x_next      = cur_pos[PW-1:Y_W];
          y_next      = cur_pos[Y_W-1:0];
          colour_next = pcol_arr[slot[K_W-1:0]];
          slot_next   = slot + 1'b1;
        end
      end

      CLEAR: begin
        plot_next = 1'b1;
        x_next    = X_W'(cx);
        y_next    = Y_W'(cy);
        if (cx == CX_W'(SCREEN_W - 1)) begin
          cx_next = '0;
          if (cy == CY_W'(SCREEN_H - 1)) begin
            cy_next    = '0;
            state_next = GLYPH;
            gp_next    = '0;
            gcol_next  = '0;
            grow_next  = '0;
            gk_next    = '0;
          end else begin
            cy_next = cy + 1'b1;
          end
        end else begin
          cx_next = cx + 1'b1;
        end
      end

      GLYPH: begin
        plot_next   = 1'b1;
        x_next      = X_W'(32'(GLYPH_X0) + 32'(gk) * 32'(GLYPH_PITCH) + 32'(gcol));
        y_next      = Y_W'(32'(GLYPH_Y0) + 32'(grow));
        colour_next = glyph_arr[gk][bit_idx] ? rcol_arr[gk] : 3'b000;
        // Player index is the inner loop so all glyphs fill in together.
        if (gk == K_W'(NUM_PLAYERS - 1)) begin
          gk_next = '0;
          if (gp == GP_W'(GN - 1)) begin
            state_next = DONE;
          end else begin
            gp_next = gp + 1'b1;
            if (gcol == GC_W'(GLYPH_W - 1)) begin
              gcol_next = '0;
              grow_next = grow + 1'b1;
            end else begin
              gcol_next = gcol + 1'b1;
            end
          end
        end else begin
          gk_next = gk + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tron_frame_sequencer.sv
// Scoreboard bench for tron_frame_sequencer: stimulus queues expected pixels,
// a negedge monitor pops one entry per plotted pixel and compares.
module tb_tron_frame_sequencer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       run;
  } pix_t;

  logic         clk = 1'b0;
  logic         resetn, start, tick;
  logic [59:0]  player_pos;
  logic [11:0]  player_colour, rank_colour;
  logic [139:0] glyph_bits;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         plot, running, done;

  pix_t       exp_q[$];
  pix_t       mon_e;
  int         checks   = 0;
  int         failures = 0;
  int         pix_idx  = 0;
  int         cyc;
  logic       plot_seen;
  logic [34:0] bm[4];
  logic [2:0]  rc[4];

  always #5 clk = ~clk;

  tron_frame_sequencer dut (
    .CLOCK_50      (clk),
    .resetn        (resetn),
    .start         (start),
    .tick          (tick),
    .player_pos    (player_pos),
    .player_colour (player_colour),
    .rank_colour   (rank_colour),
    .glyph_bits    (glyph_bits),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .running       (running),
    .done          (done)
  );

  // Monitor: every plotted pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (resetn && plot) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_plot got x=%0d y=%0d c=%b run=%b done=%b", x, y, colour, running, done);
      end else begin
        mon_e = exp_q.pop_front();
        if (x !== mon_e.x || y !== mon_e.y || colour !== mon_e.c || running !== mon_e.run || done !== 1'b0) begin
          failures++;
          $display("FAIL pixel[%0d] got x=%0d y=%0d c=%b run=%b done=%b want x=%0d y=%0d c=%b run=%b done=0",
                   pix_idx, x, y, colour, running, done, mon_e.x, mon_e.y, mon_e.c, mon_e.run);
        end
      end
      pix_idx++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input int px, input int py, input logic [2:0] c, input logic run);
    pix_t e;
    e.x = px[7:0];
    e.y = py[6:0];
    e.c = c;
    e.run = run;
    exp_q.push_back(e);
  endtask

  // 160 sweeps; tick lands on every timer slot so sweep m shows timer x = m.
  task automatic push_play();
    for (int m = 0; m < 160; m++) begin
      push(10, 20, 3'b001, 1'b1);
      push(20, 30, 3'b010, 1'b1);
      push(30, 40, 3'b100, 1'b1);
      push(40, 50, 3'b110, 1'b1);
      push(m, 119, 3'b111, 1'b1);
    end
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) push(i % 160, i / 160, 3'b000, 1'b0);
  endtask

  task automatic push_glyph();
    for (int p = 0; p < 35; p++)
      for (int k = 0; k < 4; k++)
        push(33 + 30*k + (p % 5), 42 + (p / 5), bm[k][34-p] ? rc[k] : 3'b000, 1'b0);
  endtask

  // Called at a negedge: start pulse, then 800 cycles with a tick on each timer slot.
  task automatic play_round();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      tick = (i % 5 == 0);
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bm[0] = {5'b11100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b11111};
    bm[1] = '1;
    bm[2] = '0;
    bm[3] = 35'h555555555;
    rc[0] = 3'b010; rc[1] = 3'b011; rc[2] = 3'b101; rc[3] = 3'b111;
    player_pos    = {8'd40, 7'd50, 8'd30, 7'd40, 8'd20, 7'd30, 8'd10, 7'd20};
    player_colour = {3'b110, 3'b100, 3'b010, 3'b001};
    rank_colour   = {rc[3], rc[2], rc[1], rc[0]};
    glyph_bits    = {bm[3], bm[2], bm[1], bm[0]};
    resetn = 1'b0;
    start  = 1'b0;
    tick   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_x", 32'(x), 0);
    check("reset_y", 32'(y), 0);
    check("reset_colour", 32'(colour), 0);
    check("reset_flags", {29'd0, plot, running, done}, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_plot", 32'(plot), 0);

    $display("round 1: play, expiry, clear, glyph");
    push_play();
    push_clear(19200);
    push_glyph();
    play_round();
    cyc = 0;
    while (!done && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 5);
      tick  = (cyc == 5 || cyc == 6);
    end
    start = 1'b0;
    tick  = 1'b0;
    check("done_latency", 32'(cyc), 19341);
    check("done_flags", {29'd0, done, running, plot}, 32'b100);
    check("queue_drained_r1", 32'(exp_q.size()), 0);
    repeat (5) @(negedge clk);
    check("done_hold", {29'd0, done, running, plot}, 32'b100);

    $display("round 2: restart from done, reset mid-clear");
    push_play();
    push_clear(9651);
    play_round();
    cyc = 0;
    while (!(plot && x == 8'd50 && y == 7'd60) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_50_60", 32'(plot && x == 8'd50 && y == 7'd60), 1);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outputs", {14'd0, x, y, colour, plot, running, done}, 0);
    @(negedge clk);
    check("reset_hold_outputs", {14'd0, x, y, colour, plot, running, done}, 0);
    check("queue_drained_r2", 32'(exp_q.size()), 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("post-reset idle: no start, stray ticks");
    plot_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 3 == 0);
      @(negedge clk);
      plot_seen = plot_seen | plot;
    end
    tick = 1'b0;
    check("idle_after_release_plot", 32'(plot_seen), 0);
    check("idle_after_release_flags", {30'd0, running, done}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
